// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, checksummed byte stream,
// packs it into 32-bit words and writes them to instruction memory while holding the core in reset.
module imem_loader #(
    parameter int D = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_byte_valid,
    input  logic [7:0]   i_byte,
    output logic         o_byte_ready,
    output logic         o_mem_write,
    output logic [D-1:0] o_mem_addr,
    output logic [31:0]  o_mem_data,
    output logic         o_core_reset,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error
);

    localparam logic [16:0] MAX_WORDS = 17'(1 << (D - 2));
    localparam logic [D-3:0] ONE_WORD = 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   lenLo_q, lenLo_d;
    logic [15:0]  wordsLeft_q, wordsLeft_d;
    logic [D-3:0] wordCnt_q, wordCnt_d;
    logic [1:0]   byteCnt_q, byteCnt_d;
    logic [23:0]  asm_q, asm_d;
    logic [7:0]   csum_q, csum_d;
    logic         memWrite_q, memWrite_d;
    logic [D-1:0] memAddr_q, memAddr_d;
    logic [31:0]  memData_q, memData_d;
    logic         accept;
    logic [15:0]  lenWord;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            lenLo_q     <= '0;
            wordsLeft_q <= '0;
            wordCnt_q   <= '0;
            byteCnt_q   <= '0;
            asm_q       <= '0;
            csum_q      <= '0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
        end else begin
            state_q     <= state_d;
            lenLo_q     <= lenLo_d;
            wordsLeft_q <= wordsLeft_d;
            wordCnt_q   <= wordCnt_d;
            byteCnt_q   <= byteCnt_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lenLo_d     = lenLo_q;
        wordsLeft_d = wordsLeft_q;
        wordCnt_d   = wordCnt_q;
        byteCnt_d   = byteCnt_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        memWrite_d  = 1'b0;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        accept      = i_byte_valid && o_byte_ready;
        lenWord     = {i_byte, lenLo_q};

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    state_d     = LEN_LO;
                    wordsLeft_d = '0;
                    wordCnt_d   = '0;
                    byteCnt_d   = '0;
                    asm_d       = '0;
                    csum_d      = '0;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    lenLo_d = i_byte;
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    wordsLeft_d = lenWord;
                    if (lenWord == 16'd0) begin
                        state_d = CSUM;
                    end else if ({1'b0, lenWord} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_d    = csum_q + i_byte;
                    byteCnt_d = byteCnt_q + 2'd1;
                    case (byteCnt_q)
                        2'd0: asm_d[7:0]   = i_byte;
                        2'd1: asm_d[15:8]  = i_byte;
                        2'd2: asm_d[23:16] = i_byte;
                        default: begin
                            // Fourth byte completes the word; the write is registered for next cycle
                            memWrite_d  = 1'b1;
                            memAddr_d   = {wordCnt_q, 2'b00};
                            memData_d   = {i_byte, asm_q};
                            wordCnt_d   = wordCnt_q + ONE_WORD;
                            wordsLeft_d = wordsLeft_q - 16'd1;
                            if (wordsLeft_q == 16'd1) begin
                                state_d = CSUM;
                            end
                        end
                    endcase
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (i_byte == csum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                          (state_q == DATA)   || (state_q == CSUM);
    assign o_busy       = o_byte_ready;
    assign o_done       = (state_q == DONE);
    assign o_error      = (state_q == ERROR);
    assign o_core_reset = (state_q != DONE);
    assign o_mem_write  = memWrite_q;
    assign o_mem_addr   = memAddr_q;
    assign o_mem_data   = memData_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: streams hand-built loads and
// compares status flags and the captured write sequence with bench-side expectations.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte = 8'h00;
    logic        o_byte_ready;
    logic        o_mem_write;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_core_reset;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int checks = 0;
    int failures = 0;
    int badResetWrites = 0;
    logic resetPrev = 1'b1;
    logic [7:0]  csumModel;
    logic [7:0]  stream[$];
    logic [31:0] expAddr[$];
    logic [31:0] expData[$];
    logic [31:0] wrAddr[$];
    logic [31:0] wrData[$];

    imem_loader #(.D(8)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_mem_write  (o_mem_write),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_core_reset (o_core_reset),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    // Capture every write strobe mid-cycle; flag any strobe in or just after a reset cycle
    always @(negedge i_clk) begin
        if (o_mem_write) begin
            wrAddr.push_back(32'(o_mem_addr));
            wrData.push_back(o_mem_data);
            if (i_reset || resetPrev) badResetWrites++;
        end
        resetPrev = i_reset;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int guard;
        guard = 0;
        repeat (gap) @(negedge i_clk);
        @(negedge i_clk);
        i_byte_valid = 1'b1;
        i_byte = b;
        while (!o_byte_ready && guard < 20) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 20) checkOutput("byte_ready_timeout", {31'b0, o_byte_ready}, 32'd1);
        @(posedge i_clk);
        #1 i_byte_valid = 1'b0;
    endtask

    task automatic pulseStart();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    task automatic beginLoad(input logic [15:0] n);
        stream.delete();
        expAddr.delete();
        expData.delete();
        wrAddr.delete();
        wrData.delete();
        csumModel = 8'h00;
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
    endtask

    task automatic pushWord(input logic [31:0] w);
        logic [7:0] b;
        expAddr.push_back(32'(expAddr.size() * 4));
        expData.push_back(w);
        for (int j = 0; j < 4; j++) begin
            b = w[8*j +: 8];
            stream.push_back(b);
            csumModel = csumModel + b;
        end
    endtask

    task automatic sendRange(input int first, input int last, input int maxGap);
        for (int i = first; i <= last; i++) begin
            applyStimulus(stream[i], (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0)));
        end
    endtask

    task automatic checkWrites(input string tag);
        int n;
        checkOutput({tag, "_count"}, 32'(wrAddr.size()), 32'(expAddr.size()));
        n = (wrAddr.size() < expAddr.size()) ? wrAddr.size() : expAddr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], expAddr[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], expData[i]);
        end
    endtask

    task automatic checkStatus(input string tag, input logic ready, input logic busy,
                               input logic done, input logic err, input logic coreRst);
        checkOutput({tag, "_ready"}, {31'b0, o_byte_ready}, {31'b0, ready});
        checkOutput({tag, "_busy"}, {31'b0, o_busy}, {31'b0, busy});
        checkOutput({tag, "_done"}, {31'b0, o_done}, {31'b0, done});
        checkOutput({tag, "_error"}, {31'b0, o_error}, {31'b0, err});
        checkOutput({tag, "_core_reset"}, {31'b0, o_core_reset}, {31'b0, coreRst});
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge i_clk);
        checkStatus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_mem_write", {31'b0, o_mem_write}, 32'd0);
        checkOutput("reset_mem_addr", 32'(o_mem_addr), 32'd0);
        checkOutput("reset_mem_data", o_mem_data, 32'd0);
        i_reset = 1'b0;

        // Single word, good checksum: 01 00 13 00 00 00 13
        beginLoad(16'd1);
        pushWord(32'h0000_0013);
        stream.push_back(csumModel);
        pulseStart();
        @(negedge i_clk);
        checkStatus("one_busy", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        sendRange(0, stream.size() - 1, 0);
        repeat (2) @(negedge i_clk);
        checkStatus("one_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWrites("one");

        // Two words, start pulse mid-payload must be ignored
        beginLoad(16'd2);
        pushWord(32'h0050_0093);
        pushWord(32'h0010_0113);
        stream.push_back(csumModel);
        checkOutput("two_csum_model", {24'b0, csumModel}, 32'h07);
        pulseStart();
        sendRange(0, 5, 0);
        pulseStart();
        sendRange(6, stream.size() - 1, 0);
        repeat (2) @(negedge i_clk);
        checkStatus("two_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWrites("two");

        // Single word, bad checksum 0x14: write still happens, then ERROR
        beginLoad(16'd1);
        pushWord(32'h0000_0013);
        stream.push_back(8'h14);
        pulseStart();
        sendRange(0, stream.size() - 1, 0);
        repeat (2) @(negedge i_clk);
        checkStatus("badcsum_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkWrites("badcsum");

        // Zero-length load goes straight to the checksum byte
        beginLoad(16'd0);
        stream.push_back(8'h00);
        pulseStart();
        sendRange(0, stream.size() - 1, 0);
        repeat (2) @(negedge i_clk);
        checkStatus("empty_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWrites("empty");

        // N=65 exceeds 64-word capacity: ERROR right after LEN_HI
        beginLoad(16'd65);
        pulseStart();
        sendRange(0, 1, 0);
        @(negedge i_clk);
        checkStatus("oversize_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge i_clk);
        checkWrites("oversize");

        // Full 64-word load with random valid gaps
        beginLoad(16'd64);
        for (int k = 0; k < 64; k++) begin
            pushWord({8'(k * 29 + 7), 8'(k ^ 8'hA5), 8'(k * 3 + 8'h3C), 8'(~k)});
        end
        stream.push_back(csumModel);
        pulseStart();
        sendRange(0, stream.size() - 1, 3);
        repeat (2) @(negedge i_clk);
        checkStatus("full_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWrites("full");

        // Reset mid-word, then a fresh single-word load
        beginLoad(16'd1);
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        checkStatus("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("midreset_writes", 32'(wrAddr.size()), 32'd0);
        beginLoad(16'd1);
        pushWord(32'h0000_0013);
        stream.push_back(csumModel);
        pulseStart();
        sendRange(0, stream.size() - 1, 1);
        repeat (2) @(negedge i_clk);
        checkStatus("fresh_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkWrites("fresh");
        checkOutput("reset_cycle_writes", 32'(badResetWrites), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
